mmio_io_controller: RTL and testbench
=====================================

Name: mmio_io_controller

Overview:
- Memory-mapped I/O peripheral on the data-memory bus, downstream of the single-cycle core's main ALU (address) and register-file rs2 (store data).
- Claims the 0xF0000000 I/O window.
- Holds the HEX, LEDR and LEDG output registers.
- Synchronizes and debounces SW and KEY, and keeps sticky key-press flags.
- Returns read data combinationally, so a load completes in the same cycle; the data-memory read mux selects this data using isIO.

Parameters:
- DBITS, 32, bus address/data width
- ADDR_HEX, 32'hF0000000, HEX register (R/W, bits [15:0])
- ADDR_LEDR, 32'hF0000004, LEDR register (R/W, bits [9:0])
- ADDR_LEDG, 32'hF0000008, LEDG register (R/W, bits [7:0])
- ADDR_KEY, 32'hF0000010, debounced key state (RO, bits [3:0], 1 = pressed)
- ADDR_SW, 32'hF0000014, debounced switch state (RO, bits [9:0])
- ADDR_KEYCTRL, 32'hF0000110, sticky press flags (bits [3:0], write-1-to-clear)
- DEBOUNCE_CYCLES, 16'd50000, stable cycles required before a debounced bank updates; legal range 2..65535

Ports:
- clk  input  1  system clock (PLL output)
- reset  input  1  asynchronous, active-high reset
- wrtEn  input  1  store enable from controller
- addr  input  DBITS  byte address (main ALU output)
- dIn  input  DBITS  store data (rs2)
- sw  input  10  raw switches, asynchronous
- key  input  4  raw pushbuttons, asynchronous, active-low
- ledr  output  10  LEDR register
- ledg  output  8  LEDG register
- hex  output  16  HEX register; [15:12] drives the leftmost digit
- dOut  output  DBITS  read data, zero-extended
- isIO  output  1  high when addr matches any I/O address above

Behaviour:
- Reset (async assert, release on clk edge): ledr, ledg, hex, debounced SW, debounced KEY, sticky flags, both debounce counters and all synchronizer flops go to 0. Reset asserted mid-debounce discards the partial count.
- Address decode is full 32-bit equality. Unmatched addresses give isIO=0 and dOut=0. Writes to unmatched addresses, ADDR_KEY or ADDR_SW are ignored.
- Writes take effect at posedge clk when wrtEn is high and the address matches:
  - HEX takes dIn[15:0].
  - LEDR takes dIn[9:0].
  - LEDG takes dIn[7:0].
  - KEYCTRL clears each flag i where dIn[i]=1.
- Reads are combinational from the current registers. A read in the same cycle as a write to the same register returns the old value.
- Synchronization: each raw input passes through 2 flops. key is inverted before synchronization, so internally 1 means pressed.
- Debounce runs per bank (SW bank 10 bits, KEY bank 4 bits), each with its own 16-bit counter:
  - If synced == stable: counter is cleared to 0.
  - If synced != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If synced != stable and counter == DEBOUNCE_CYCLES-1: stable takes synced and counter is cleared.
  - If the synced value changes again during the count, the counter does not restart. Any return to equality clears it.
- Latency: a raw change held steady is visible in the stable value (and dOut) DEBOUNCE_CYCLES+2 rising edges after the edge on which it first becomes setup-valid.
- Sticky flags: flag i sets on the edge where debounced KEY[i] goes 0->1. If a set and a W1C clear hit the same bit on the same edge, the set wins. Release of the key does not clear the flag.
- Counters never wrap, because they are bounded by DEBOUNCE_CYCLES-1.

Test Plan:
- Reset: assert reset asynchronously mid-clock -> ledr=0, ledg=0, hex=0 immediately. A read of ADDR_SW then returns 0 with isIO=1.
- Writes and decode: store 0x0000ABCD to ADDR_HEX, 0x3FF to ADDR_LEDR, 0x1A5 to ADDR_LEDG -> hex=16'hABCD, ledr=10'h3FF, ledg=8'hA5. A store to 0xF000000C leaves all outputs unchanged with isIO=0, dOut=0.
- Debounce latency (DEBOUNCE_CYCLES=4): sw 0x000->0x2AA held -> ADDR_SW read returns 0x000 through edge 5 and 0x2AA after edge 6. A glitch lasting 3 cycles produces no change.
- Key sticky flag (DEBOUNCE_CYCLES=4): key[2] driven low for 10 cycles then high -> ADDR_KEY reads 0x4 while pressed, then 0x0. ADDR_KEYCTRL reads 0x4 until 0x4 is written, then reads 0x0.
- Set/clear collision: W1C of 0xF on the same edge that debounced KEY[0] rises -> KEYCTRL reads 0x1 afterwards.
- Read-during-write: read ADDR_LEDR while storing 0x155 in the same cycle -> dOut holds the old value; the next cycle returns 0x155.

Source files
------------

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O peripheral for the 0xF0000000 window: HEX/LEDR/LEDG registers,
// synchronized and debounced SW/KEY banks, and sticky key-press flags (write-1-to-clear).
module mmio_io_controller #(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KEYCTRL    = 32'hF0000110,
  parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] dIn,
  input  logic [9:0]       sw,
  input  logic [3:0]       key,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [15:0]      hex,
  output logic [DBITS-1:0] dOut,
  output logic             isIO
);

  logic selHex, selLedr, selLedg, selKey, selSw, selKeyCtrl;
  logic [9:0]  swMeta, swSync, swStable, swStableNext;
  logic [3:0]  keyMeta, keySync, keyStable, keyStableNext;
  logic [15:0] swCnt, swCntNext, keyCnt, keyCntNext;
  logic [3:0]  keyFlags, keyRise, keyClr;
  logic        unusedDin;

  assign unusedDin = ^dIn[DBITS-1:16];

  assign selHex     = (addr == ADDR_HEX);
  assign selLedr    = (addr == ADDR_LEDR);
  assign selLedg    = (addr == ADDR_LEDG);
  assign selKey     = (addr == ADDR_KEY);
  assign selSw      = (addr == ADDR_SW);
  assign selKeyCtrl = (addr == ADDR_KEYCTRL);
  assign isIO       = selHex | selLedr | selLedg | selKey | selSw | selKeyCtrl;

  always_comb begin
    dOut = '0;
    if (selHex)     dOut[15:0] = hex;
    if (selLedr)    dOut[9:0]  = ledr;
    if (selLedg)    dOut[7:0]  = ledg;
    if (selKey)     dOut[3:0]  = keyStable;
    if (selSw)      dOut[9:0]  = swStable;
    if (selKeyCtrl) dOut[3:0]  = keyFlags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex  <= '0;
      ledr <= '0;
      ledg <= '0;
    end else if (wrtEn) begin
      if (selHex)  hex  <= dIn[15:0];
      if (selLedr) ledr <= dIn[9:0];
      if (selLedg) ledg <= dIn[7:0];
    end
  end

  // Keys are inverted ahead of the synchronizer so that 1 means pressed everywhere inside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swMeta  <= '0;
      swSync  <= '0;
      keyMeta <= '0;
      keySync <= '0;
    end else begin
      swMeta  <= sw;
      swSync  <= swMeta;
      keyMeta <= ~key;
      keySync <= keyMeta;
    end
  end

  // The count keeps running across further changes of the synced value; only equality clears it.
  always_comb begin
    swCntNext    = '0;
    swStableNext = swStable;
    if (swSync != swStable) begin
      if (swCnt == DEBOUNCE_CYCLES - 16'd1) swStableNext = swSync;
      else                                  swCntNext    = swCnt + 16'd1;
    end
  end

  always_comb begin
    keyCntNext    = '0;
    keyStableNext = keyStable;
    if (keySync != keyStable) begin
      if (keyCnt == DEBOUNCE_CYCLES - 16'd1) keyStableNext = keySync;
      else                                   keyCntNext    = keyCnt + 16'd1;
    end
  end

  assign keyRise = keyStableNext & ~keyStable;
  assign keyClr  = (wrtEn && selKeyCtrl) ? dIn[3:0] : 4'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swCnt     <= '0;
      swStable  <= '0;
      keyCnt    <= '0;
      keyStable <= '0;
      keyFlags  <= '0;
    end else begin
      swCnt     <= swCntNext;
      swStable  <= swStableNext;
      keyCnt    <= keyCntNext;
      keyStable <= keyStableNext;
      keyFlags  <= (keyFlags & ~keyClr) | keyRise;
    end
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Self-checking bench for mmio_io_controller with a short debounce window; expected
// read values are queued when stimulus is driven and compared when the read data is sampled.
module tb_mmio_io_controller;
  localparam logic [31:0] A_HEX     = 32'hF0000000;
  localparam logic [31:0] A_LEDR    = 32'hF0000004;
  localparam logic [31:0] A_LEDG    = 32'hF0000008;
  localparam logic [31:0] A_KEY     = 32'hF0000010;
  localparam logic [31:0] A_SW      = 32'hF0000014;
  localparam logic [31:0] A_KEYCTRL = 32'hF0000110;

  logic        clk = 0;
  logic        reset = 1;
  logic        wrtEn = 0;
  logic [31:0] addr = 0;
  logic [31:0] dIn = 0;
  logic [9:0]  sw = 0;
  logic [3:0]  key = 4'hF;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [15:0] hex;
  logic [31:0] dOut;
  logic        isIO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expItem;
  expItem expQ[$];

  mmio_io_controller #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .addr(addr), .dIn(dIn),
    .sw(sw), .key(key), .ledr(ledr), .ledg(ledg), .hex(hex),
    .dOut(dOut), .isIO(isIO)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] exp);
    expItem it;
    it.tag = tag;
    it.exp = exp;
    expQ.push_back(it);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    expItem it;
    if (expQ.size() == 0) begin
      checkEq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      it = expQ.pop_front();
      checkEq(it.tag, obs, it.exp);
    end
  endtask

  // Combinational read at the current time (called just after a falling edge).
  task automatic readCheck(input logic [31:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    pushExp(tag, exp);
    #1;
    popCheck(dOut);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; dIn = d; wrtEn = 1;
    @(negedge clk);
    wrtEn = 0;
  endtask

  initial begin
    #1;
    checkEq("rst_ledr", {22'd0, ledr}, 32'd0);
    checkEq("rst_ledg", {24'd0, ledg}, 32'd0);
    checkEq("rst_hex",  {16'd0, hex},  32'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;

    store(A_HEX,  32'h0000ABCD);
    store(A_LEDR, 32'h000003FF);
    store(A_LEDG, 32'h000001A5);
    checkEq("wr_hex",  {16'd0, hex},  32'h0000ABCD);
    checkEq("wr_ledr", {22'd0, ledr}, 32'h000003FF);
    checkEq("wr_ledg", {24'd0, ledg}, 32'h000000A5);
    readCheck(A_HEX, "rd_hex", 32'h0000ABCD);
    checkEq("isio_hex", {31'd0, isIO}, 32'd1);

    @(negedge clk);
    addr = 32'hF000000C; dIn = 32'hFFFFFFFF; wrtEn = 1;
    #1;
    checkEq("unmapped_isio", {31'd0, isIO}, 32'd0);
    checkEq("unmapped_dout", dOut, 32'd0);
    @(negedge clk);
    wrtEn = 0;
    checkEq("unmapped_hex",  {16'd0, hex},  32'h0000ABCD);
    checkEq("unmapped_ledr", {22'd0, ledr}, 32'h000003FF);
    checkEq("unmapped_ledg", {24'd0, ledg}, 32'h000000A5);
    store(A_SW, 32'h000003FF);
    readCheck(A_SW, "ro_sw_write", 32'd0);

    // Debounce latency: stable after edge 6, counting the first edge that sees the change.
    @(negedge clk);
    sw = 10'h2AA;
    addr = A_SW;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      readCheck(A_SW, $sformatf("sw_lat_e%0d", e), (e >= 6) ? 32'h2AA : 32'h0);
    end

    // Three-cycle glitch must be filtered.
    sw = 10'h155;
    repeat (3) @(negedge clk);
    sw = 10'h2AA;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      readCheck(A_SW, $sformatf("sw_glitch_%0d", e), 32'h2AA);
    end

    // Key 2 pressed for 10 cycles.
    key = 4'b1011;
    repeat (5) @(negedge clk);
    readCheck(A_KEY, "key_pre", 32'h0);
    @(negedge clk);
    readCheck(A_KEY, "key_pressed", 32'h4);
    @(negedge clk);
    readCheck(A_KEYCTRL, "flag_pressed", 32'h4);
    repeat (3) @(negedge clk);
    key = 4'hF;
    repeat (8) @(negedge clk);
    readCheck(A_KEY, "key_released", 32'h0);
    readCheck(A_KEYCTRL, "flag_sticky", 32'h4);
    store(A_KEYCTRL, 32'h0000_0004);
    readCheck(A_KEYCTRL, "flag_cleared", 32'h0);

    // Set wins over a simultaneous W1C on key 0.
    key = 4'b1110;
    repeat (5) @(negedge clk);
    addr = A_KEYCTRL; dIn = 32'hF; wrtEn = 1;
    @(negedge clk);
    wrtEn = 0;
    readCheck(A_KEYCTRL, "flag_set_wins", 32'h1);
    readCheck(A_KEY, "key0_pressed", 32'h1);
    key = 4'hF;
    repeat (8) @(negedge clk);
    store(A_KEYCTRL, 32'h1);
    readCheck(A_KEYCTRL, "flag0_cleared", 32'h0);

    // Read during write returns the old value.
    @(negedge clk);
    addr = A_LEDR; dIn = 32'h155; wrtEn = 1;
    pushExp("rdw_old", 32'h3FF);
    #1;
    popCheck(dOut);
    @(negedge clk);
    wrtEn = 0;
    readCheck(A_LEDR, "rdw_new", 32'h155);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    checkEq("arst_ledr", {22'd0, ledr}, 32'd0);
    checkEq("arst_ledg", {24'd0, ledg}, 32'd0);
    checkEq("arst_hex",  {16'd0, hex},  32'd0);
    readCheck(A_SW, "arst_sw", 32'd0);
    checkEq("arst_isio", {31'd0, isIO}, 32'd1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    checkEq("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
